shift_sequencer: RTL and testbench

Two-requester controller for the shared 32-bit combinational barrel shifter. It arbitrates round-robin between requesters and implements full ARM register-specified shift semantics: 8-bit amounts, amount 0, 32 and >32, RRX, and shifter carry-out. It drives the shifter's shamt5/register/sh inputs over one or two passes, then presents result plus carry on a valid/ready output. It sits between operand-2 / load-alignment requesters and the single shifter instance.

---
 rtl/shift_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_shift_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// shift_sequencer: round-robin front end for the shared 32-bit barrel shifter.
// Two requesters, full ARM register-specified shift semantics (8-bit amounts,
// amount 0 / 32 / >32, RRX, carry-out) resolved either directly at acceptance
// or over one or two passes through the external combinational shifter.
module shift_sequencer #(
    parameter bit FIRST_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rq0_valid,
    output logic        rq0_ready,
    input  logic [31:0] rq0_value,
    input  logic [7:0]  rq0_amount,
    input  logic [1:0]  rq0_type,
    input  logic        rq0_rrx,
    input  logic        rq0_cin,
    input  logic        rq1_valid,
    output logic        rq1_ready,
    input  logic [31:0] rq1_value,
    input  logic [7:0]  rq1_amount,
    input  logic [1:0]  rq1_type,
    input  logic        rq1_rrx,
    input  logic        rq1_cin,
    output logic [4:0]  sh_shamt5,
    output logic [31:0] sh_register,
    output logic [1:0]  sh_sh,
    input  logic [31:0] sh_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_id,
    output logic [31:0] out_result,
    output logic        out_carry
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS1 = 2'd1,
        PASS2 = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    state_t      state_q, state_d;
    logic        prio_q, prio_d;
    logic        id_q, id_d;
    logic [31:0] value_q, value_d;
    logic [4:0]  amount_q, amount_d;
    logic [1:0]  type_q, type_d;
    logic [31:0] result_q, result_d;
    logic        carry_q, carry_d;

    logic        grant0, grant1, accept;
    logic [31:0] sel_value;
    logic [7:0]  sel_amount;
    logic [1:0]  sel_type;
    logic        sel_rrx, sel_cin;

    state_t      cls_state;
    logic [31:0] cls_result;
    logic        cls_carry;

    // Round-robin grant (pointer holder wins a tie) and payload mux of the winner
    always_comb begin
        grant0     = rq0_valid && (!rq1_valid || (prio_q == 1'b0));
        grant1     = rq1_valid && (!rq0_valid || (prio_q == 1'b1));
        rq0_ready  = (state_q == IDLE) && reset && grant0;
        rq1_ready  = (state_q == IDLE) && reset && grant1;
        accept     = rq0_ready || rq1_ready;
        sel_value  = grant1 ? rq1_value  : rq0_value;
        sel_amount = grant1 ? rq1_amount : rq0_amount;
        sel_type   = grant1 ? rq1_type   : rq0_type;
        sel_rrx    = grant1 ? rq1_rrx    : rq0_rrx;
        sel_cin    = grant1 ? rq1_cin    : rq0_cin;
    end

    // Resolve ARM corner cases at acceptance; otherwise choose the pass path
    always_comb begin
        cls_state  = DONE;
        cls_result = sel_value;
        cls_carry  = sel_cin;
        if (sel_rrx) begin
            cls_result = {sel_cin, sel_value[31:1]};
            cls_carry  = sel_value[0];
        end else if (sel_amount != 8'd0) begin
            case (sel_type)
                SH_LSL: begin
                    if (sel_amount == 8'd32) begin
                        cls_result = '0;
                        cls_carry  = sel_value[0];
                    end else if (sel_amount > 8'd32) begin
                        cls_result = '0;
                        cls_carry  = 1'b0;
                    end else begin
                        cls_state = PASS1;
                    end
                end
                SH_LSR: begin
                    if (sel_amount == 8'd32) begin
                        cls_result = '0;
                        cls_carry  = sel_value[31];
                    end else if (sel_amount > 8'd32) begin
                        cls_result = '0;
                        cls_carry  = 1'b0;
                    end else begin
                        cls_state = PASS1;
                    end
                end
                SH_ASR: begin
                    if (sel_amount >= 8'd32) begin
                        cls_result = {32{sel_value[31]}};
                        cls_carry  = sel_value[31];
                    end else begin
                        cls_state = PASS1;
                    end
                end
                default: begin
                    if (sel_amount[4:0] == 5'd0) begin
                        cls_carry = sel_value[31];
                    end else begin
                        cls_state = PASS2;
                    end
                end
            endcase
        end
    end

    // Next state, shifter drive (carry pass by n-1, then result pass by n) and capture
    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        id_d        = id_q;
        value_d     = value_q;
        amount_d    = amount_q;
        type_d      = type_q;
        result_d    = result_q;
        carry_d     = carry_q;
        sh_shamt5   = '0;
        sh_register = '0;
        sh_sh       = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    id_d     = grant1;
                    prio_d   = ~grant1;
                    value_d  = sel_value;
                    amount_d = sel_amount[4:0];
                    type_d   = sel_type;
                    result_d = cls_result;
                    carry_d  = cls_carry;
                    state_d  = cls_state;
                end
            end
            PASS1: begin
                sh_shamt5   = amount_q - 5'd1;
                sh_register = value_q;
                sh_sh       = type_q;
                carry_d     = (type_q == SH_LSL) ? sh_result[31] : sh_result[0];
                state_d     = PASS2;
            end
            PASS2: begin
                sh_shamt5   = amount_q;
                sh_register = value_q;
                sh_sh       = type_q;
                result_d    = sh_result;
                if (type_q == SH_ROR) begin
                    carry_d = sh_result[31];
                end
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and request registers; reset abandons any request in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            prio_q   <= FIRST_PRIO;
            id_q     <= 1'b0;
            value_q  <= '0;
            amount_q <= '0;
            type_q   <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            id_q     <= id_d;
            value_q  <= value_d;
            amount_q <= amount_d;
            type_q   <= type_d;
            result_q <= result_d;
            carry_q  <= carry_d;
        end
    end

    // Result port is driven only while a result is being offered
    always_comb begin
        out_valid  = (state_q == DONE);
        out_id     = out_valid && id_q;
        out_result = out_valid ? result_q : '0;
        out_carry  = out_valid && carry_q;
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: scoreboard bench for shift_sequencer with a behavioural
// barrel shifter attached to the sh_* port and an independent ARM shift model.
module tb_shift_sequencer;

    localparam bit FIRST_PRIO = 1'b0;
    localparam logic [1:0] LSL = 2'b00;
    localparam logic [1:0] LSR = 2'b01;
    localparam logic [1:0] ASR = 2'b10;
    localparam logic [1:0] ROR = 2'b11;

    logic        clk = 1'b0;
    logic        reset;
    logic        rq0_valid = 1'b0, rq0_ready, rq0_rrx = 1'b0, rq0_cin = 1'b0;
    logic [31:0] rq0_value = '0;
    logic [7:0]  rq0_amount = '0;
    logic [1:0]  rq0_type = '0;
    logic        rq1_valid = 1'b0, rq1_ready, rq1_rrx = 1'b0, rq1_cin = 1'b0;
    logic [31:0] rq1_value = '0;
    logic [7:0]  rq1_amount = '0;
    logic [1:0]  rq1_type = '0;
    logic [4:0]  sh_shamt5;
    logic [31:0] sh_register, sh_result;
    logic [1:0]  sh_sh;
    logic        out_valid, out_ready = 1'b1, out_id, out_carry;
    logic [31:0] out_result;

    typedef struct {
        logic        id;
        logic [31:0] result;
        logic        carry;
        int          lat;
        int          acc_cyc;
    } exp_t;

    exp_t sb[$];
    logic grant_log[$];
    int   n_vec = 0;
    int   n_miss = 0;
    int   cyc = 0;
    logic busy = 1'b0;
    logic mdl_prio = FIRST_PRIO;
    logic prev_valid = 1'b0;

    shift_sequencer #(.FIRST_PRIO(FIRST_PRIO)) dut (
        .clk(clk), .reset(reset),
        .rq0_valid(rq0_valid), .rq0_ready(rq0_ready), .rq0_value(rq0_value),
        .rq0_amount(rq0_amount), .rq0_type(rq0_type), .rq0_rrx(rq0_rrx), .rq0_cin(rq0_cin),
        .rq1_valid(rq1_valid), .rq1_ready(rq1_ready), .rq1_value(rq1_value),
        .rq1_amount(rq1_amount), .rq1_type(rq1_type), .rq1_rrx(rq1_rrx), .rq1_cin(rq1_cin),
        .sh_shamt5(sh_shamt5), .sh_register(sh_register), .sh_sh(sh_sh), .sh_result(sh_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
        .out_result(out_result), .out_carry(out_carry)
    );

    // Free-running clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Behavioural model of the shared combinational barrel shifter
    always_comb begin
        case (sh_sh)
            LSL:     sh_result = sh_register << sh_shamt5;
            LSR:     sh_result = sh_register >> sh_shamt5;
            ASR:     sh_result = 32'($signed(sh_register) >>> sh_shamt5);
            default: sh_result = (sh_shamt5 == 5'd0) ? sh_register :
                                 ((sh_register >> sh_shamt5) | (sh_register << (6'd32 - {1'b0, sh_shamt5})));
        endcase
    end

    // ARM register-specified shift reference: returns {result, carry}
    function automatic logic [32:0] ref_shift(input logic [31:0] v, input logic [7:0] n,
                                              input logic [1:0] t, input logic rrx, input logic cin);
        logic [63:0] w;
        logic [4:0]  r;
        logic [31:0] res;
        if (rrx) return {cin, v[31:1], v[0]};
        if (n == 8'd0) return {v, cin};
        case (t)
            LSL: begin
                w = {32'b0, v} << n;
                return {w[31:0], w[32]};
            end
            LSR: begin
                w = {v, 32'b0} >> n;
                return {w[63:32], w[31]};
            end
            ASR: begin
                w = 64'($signed({v, 32'b0}) >>> n);
                return {w[63:32], w[31]};
            end
            default: begin
                r = n[4:0];
                res = (r == 5'd0) ? v : ((v >> r) | (v << (6'd32 - {1'b0, r})));
                return {res, res[31]};
            end
        endcase
    endfunction

    // Expected accept-to-out_valid latency in cycles
    function automatic int ref_latency(input logic [7:0] n, input logic [1:0] t, input logic rrx);
        if (rrx || n == 8'd0) return 1;
        if (t == ROR) return (n[4:0] == 5'd0) ? 1 : 2;
        return (n >= 8'd32) ? 1 : 3;
    endfunction

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_vec++;
        if (observed !== expected) begin
            n_miss++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Present one request on a requester and hold it until accepted (bounded)
    task automatic applyStimulus(input logic id, input logic [31:0] v, input logic [7:0] n,
                                 input logic [1:0] t, input logic rrx, input logic cin);
        bit accepted = 1'b0;
        if (id == 1'b0) begin
            rq0_value = v; rq0_amount = n; rq0_type = t; rq0_rrx = rrx; rq0_cin = cin; rq0_valid = 1'b1;
        end else begin
            rq1_value = v; rq1_amount = n; rq1_type = t; rq1_rrx = rrx; rq1_cin = cin; rq1_valid = 1'b1;
        end
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ((id == 1'b0) ? rq0_ready : rq1_ready) begin
                accepted = 1'b1;
                break;
            end
        end
        if (!accepted) checkOutput("accept_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
        if (id == 1'b0) rq0_valid = 1'b0;
        else            rq1_valid = 1'b0;
    endtask

    // Wait until every accepted request has been drained (bounded)
    task automatic waitIdle();
        bit drained = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) begin
                drained = 1'b1;
                break;
            end
        end
        if (!drained) checkOutput("drain_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: grant model, quiet-idle checks, scoreboard push on accept, compare on output
    always @(negedge clk) begin
        logic g0, g1, id;
        logic [32:0] e;
        exp_t x;
        if (!reset) begin
            prev_valid = 1'b0;
        end else begin
            if (busy) begin
                checkOutput("ready_busy", 64'({rq0_ready, rq1_ready}), 64'd0);
            end else begin
                g0 = rq0_valid && (!rq1_valid || mdl_prio == 1'b0);
                g1 = rq1_valid && (!rq0_valid || mdl_prio == 1'b1);
                checkOutput("grant", 64'({rq0_ready, rq1_ready}), 64'({g0, g1}));
                checkOutput("idle_quiet", 64'({out_valid, sh_shamt5, sh_register, sh_sh}), 64'd0);
            end
            if ((rq0_valid && rq0_ready) || (rq1_valid && rq1_ready)) begin
                id = rq1_ready;
                if (id == 1'b0) e = ref_shift(rq0_value, rq0_amount, rq0_type, rq0_rrx, rq0_cin);
                else            e = ref_shift(rq1_value, rq1_amount, rq1_type, rq1_rrx, rq1_cin);
                x.id      = id;
                x.result  = e[32:1];
                x.carry   = e[0];
                x.lat     = (id == 1'b0) ? ref_latency(rq0_amount, rq0_type, rq0_rrx)
                                         : ref_latency(rq1_amount, rq1_type, rq1_rrx);
                x.acc_cyc = cyc;
                sb.push_back(x);
                grant_log.push_back(id);
                busy = 1'b1;
                mdl_prio = ~id;
            end
            if (out_valid) begin
                if (sb.size() == 0) begin
                    checkOutput("spurious_out", 64'd1, 64'd0);
                end else begin
                    if (!prev_valid) checkOutput("latency", 64'(cyc - sb[0].acc_cyc), 64'(sb[0].lat));
                    checkOutput("out_id", 64'(out_id), 64'(sb[0].id));
                    checkOutput("out_result", 64'(out_result), 64'(sb[0].result));
                    checkOutput("out_carry", 64'(out_carry), 64'(sb[0].carry));
                    checkOutput("done_sh_quiet", 64'({sh_shamt5, sh_register, sh_sh}), 64'd0);
                    if (out_ready) begin
                        void'(sb.pop_front());
                        busy = 1'b0;
                    end
                end
            end
            prev_valid = out_valid && !out_ready;
        end
    end

    // Directed, round-robin, back-pressure, random and reset scenarios
    initial begin
        bit          bp_seen;
        logic        rid;
        logic [1:0]  rt;
        logic [7:0]  rn;
        int          sel;

        reset = 1'b0;
        rq0_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_ctl", 64'({out_valid, rq0_ready, rq1_ready, sh_shamt5, sh_sh, out_id, out_carry}), 64'd0);
        checkOutput("rst_data", {sh_register, out_result}, 64'd0);
        rq0_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] round-robin with both requesters valid");
        grant_log.delete();
        fork
            begin
                applyStimulus(1'b0, 32'h0000_0003, 8'd4, LSL, 1'b0, 1'b0);
                applyStimulus(1'b0, 32'h8000_0001, 8'd1, LSR, 1'b0, 1'b0);
            end
            begin
                applyStimulus(1'b1, 32'h0000_0001, 8'd1, ROR, 1'b0, 1'b0);
                applyStimulus(1'b1, 32'h8000_0000, 8'd40, ASR, 1'b0, 1'b0);
            end
        join
        waitIdle();
        checkOutput("rr_count", 64'(grant_log.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < grant_log.size()) checkOutput($sformatf("rr_grant%0d", i), 64'(grant_log[i]), 64'(i % 2));
        end

        $display("[TB] directed corner cases");
        applyStimulus(1'b0, 32'h0000_0003, 8'd4,   LSL, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h8000_0001, 8'd1,   LSR, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h8000_0000, 8'd40,  ASR, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0000_0001, 8'd32,  LSL, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hFFFF_FFFF, 8'd200, LSR, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h8000_0000, 8'd32,  LSR, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h1234_5678, 8'd0,   LSL, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h0000_0001, 8'd1,   ROR, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h8000_0000, 8'd32,  ROR, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0000_0003, 8'd77,  LSR, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'h8000_00F0, 8'd31,  ASR, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'hF000_000F, 8'd31,  LSL, 1'b0, 1'b0);
        waitIdle();

        $display("[TB] back-pressure on the output");
        out_ready = 1'b0;
        applyStimulus(1'b0, 32'h0000_0003, 8'd4, LSL, 1'b0, 1'b0);
        bp_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                bp_seen = 1'b1;
                break;
            end
        end
        if (!bp_seen) checkOutput("bp_timeout", 64'd1, 64'd0);
        fork
            begin
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
            applyStimulus(1'b1, 32'hDEAD_BEEF, 8'd8, ROR, 1'b0, 1'b0);
        join
        waitIdle();

        $display("[TB] random requests");
        for (int k = 0; k < 24; k++) begin
            rid = 1'($urandom_range(0, 1));
            rt  = 2'($urandom_range(0, 3));
            sel = $urandom_range(0, 2);
            rn  = (sel == 0) ? 8'($urandom_range(0, 255)) : (sel == 1) ? 8'($urandom_range(1, 31)) : 8'd32;
            applyStimulus(rid, $urandom, rn, rt, ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
        end
        waitIdle();

        $display("[TB] reset during the result pass");
        applyStimulus(1'b0, 32'h0000_0003, 8'd4, LSL, 1'b0, 1'b0);
        rq0_value = 32'h0000_00FF; rq0_amount = 8'd3; rq0_type = LSR; rq0_rrx = 1'b0; rq0_cin = 1'b0; rq0_valid = 1'b1;
        rq1_value = 32'h0000_0011; rq1_amount = 8'd2; rq1_type = LSL; rq1_rrx = 1'b0; rq1_cin = 1'b0; rq1_valid = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("rst_mid_ctl", 64'({out_valid, rq0_ready, rq1_ready, sh_shamt5, sh_sh}), 64'd0);
        checkOutput("rst_mid_reg", 64'(sh_register), 64'd0);
        sb.delete();
        grant_log.delete();
        busy = 1'b0;
        mdl_prio = FIRST_PRIO;
        prev_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        fork
            applyStimulus(1'b0, 32'h0000_00FF, 8'd3, LSR, 1'b0, 1'b0);
            applyStimulus(1'b1, 32'h0000_0011, 8'd2, LSL, 1'b0, 1'b0);
        join
        waitIdle();
        checkOutput("rst_regrant_count", 64'(grant_log.size()), 64'd2);
        if (grant_log.size() > 0) checkOutput("rst_regrant_first", 64'(grant_log[0]), 64'(FIRST_PRIO));

        $display("[TB] == %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
